// File: rtl/wb_loader_pkg.sv
// Shared types and byte-lane constants for the HPS download-to-SDRAM loader.
package wb_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERASE = 3'd1,
    LOAD  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [3:0] SEL_LO  = 4'b0011;
  localparam logic [3:0] SEL_HI  = 4'b1100;
  localparam logic [3:0] SEL_ALL = 4'b1111;

endpackage

// File: rtl/wb_rom_loader.sv
// Zero-fills a RAM region over Wishbone on download start, then writes streamed ioctl half-words.
// Optional build macro LOADER_CHECKSUM_EN enables the running sum on checksum_o.
//
// state | meaning
// IDLE  | bus released, waiting for rising dl_active
// ERASE | writing zero to every word of the region
// LOAD  | forwarding ioctl half-words (optionally packed) to the bus
// FLUSH | writing a leftover low half after the download ended
// DONE  | one-cycle completion pulse
module wb_rom_loader
  import wb_loader_pkg::*;
#(
  parameter int              ADDR_W      = 22,
  parameter logic [ADDR_W-1:0] BASE_WORD = 'h100000,
  parameter int              REGION_LOG2 = 20,
  parameter bit              PACK        = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active_i,
  input  logic              dl_wr_i,
  input  logic [24:0]       dl_addr_i,
  input  logic [15:0]       dl_data_i,
  output logic              dl_wait_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_ack_i,
  output logic              own_bus_o,
  output logic              done_o,
  output logic [31:0]       checksum_o
);

  localparam logic [ADDR_W-1:0]      REGION_MASK = ADDR_W'((64'd1 << REGION_LOG2) - 64'd1);
  localparam logic [REGION_LOG2-1:0] CNT_ONE     = REGION_LOG2'(1);
  localparam logic [REGION_LOG2-1:0] CNT_LAST    = '1;

  state_e                 state_q, state_d;
  logic                   dl_active_q;
  logic                   stb_q, stb_d;
  logic                   wait_q, wait_d;
  logic [3:0]             sel_q, sel_d;
  logic [ADDR_W-1:0]      adr_q, adr_d;
  logic [31:0]            dat_q, dat_d;
  logic [REGION_LOG2-1:0] erase_cnt_q, erase_cnt_d;
  logic                   hold_v_q, hold_v_d;
  logic [15:0]            hold_q, hold_d;
  logic [ADDR_W-1:0]      hold_adr_q, hold_adr_d;
  logic                   pend_v_q, pend_v_d;
  logic [15:0]            pend_dat_q, pend_dat_d;
  logic [ADDR_W-1:0]      pend_adr_q, pend_adr_d;
  logic [ADDR_W-1:0]      load_word;
  logic                   accept_wr;
  logic                   unused_addr_bit0;

  // dl_addr bit 0 addresses a byte inside the half-word and has no meaning here
  assign unused_addr_bit0 = dl_addr_i[0];
  assign load_word = BASE_WORD + (ADDR_W'(dl_addr_i[24:2]) & REGION_MASK);
  assign accept_wr = (state_q == LOAD) && !stb_q && dl_wr_i;

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    wait_d      = wait_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    erase_cnt_d = erase_cnt_q;
    hold_v_d    = hold_v_q;
    hold_d      = hold_q;
    hold_adr_d  = hold_adr_q;
    pend_v_d    = pend_v_q;
    pend_dat_d  = pend_dat_q;
    pend_adr_d  = pend_adr_q;
    case (state_q)
      IDLE: begin
        stb_d  = 1'b0;
        wait_d = 1'b0;
        if (dl_active_i && !dl_active_q) begin
          state_d     = ERASE;
          stb_d       = 1'b1;
          wait_d      = 1'b1;
          sel_d       = SEL_ALL;
          dat_d       = 32'd0;
          adr_d       = BASE_WORD;
          erase_cnt_d = '0;
          hold_v_d    = 1'b0;
          pend_v_d    = 1'b0;
        end
      end
      ERASE: begin
        if (wb_ack_i) begin
          if (!dl_active_i || erase_cnt_q == CNT_LAST) begin
            state_d = dl_active_i ? LOAD : IDLE;
            stb_d   = 1'b0;
            wait_d  = 1'b0;
          end else begin
            erase_cnt_d = erase_cnt_q + CNT_ONE;
            adr_d       = BASE_WORD + ADDR_W'(erase_cnt_q + CNT_ONE);
          end
        end
      end
      LOAD: begin
        if (stb_q) begin
          if (wb_ack_i) begin
            // a mismatched high half waits behind the orphaned low half
            if (pend_v_q) begin
              adr_d    = pend_adr_q;
              dat_d    = {pend_dat_q, pend_dat_q};
              sel_d    = SEL_HI;
              pend_v_d = 1'b0;
            end else begin
              stb_d  = 1'b0;
              wait_d = 1'b0;
            end
          end
        end else if (dl_wr_i) begin
          if (!PACK) begin
            stb_d  = 1'b1;
            wait_d = 1'b1;
            adr_d  = load_word;
            dat_d  = {dl_data_i, dl_data_i};
            sel_d  = dl_addr_i[1] ? SEL_HI : SEL_LO;
          end else if (!dl_addr_i[1]) begin
            hold_v_d   = 1'b1;
            hold_d     = dl_data_i;
            hold_adr_d = load_word;
          end else if (hold_v_q && hold_adr_q == load_word) begin
            stb_d    = 1'b1;
            wait_d   = 1'b1;
            adr_d    = load_word;
            dat_d    = {dl_data_i, hold_q};
            sel_d    = SEL_ALL;
            hold_v_d = 1'b0;
          end else if (hold_v_q) begin
            stb_d      = 1'b1;
            wait_d     = 1'b1;
            adr_d      = hold_adr_q;
            dat_d      = {hold_q, hold_q};
            sel_d      = SEL_LO;
            hold_v_d   = 1'b0;
            pend_v_d   = 1'b1;
            pend_dat_d = dl_data_i;
            pend_adr_d = load_word;
          end else begin
            stb_d  = 1'b1;
            wait_d = 1'b1;
            adr_d  = load_word;
            dat_d  = {dl_data_i, dl_data_i};
            sel_d  = SEL_HI;
          end
        end else if (!dl_active_i) begin
          if (hold_v_q) begin
            state_d = FLUSH;
            stb_d   = 1'b1;
            wait_d  = 1'b1;
            adr_d   = hold_adr_q;
            dat_d   = {hold_q, hold_q};
            sel_d   = SEL_LO;
          end else begin
            state_d = DONE;
          end
        end
      end
      FLUSH: begin
        if (wb_ack_i) begin
          state_d  = DONE;
          stb_d    = 1'b0;
          wait_d   = 1'b0;
          hold_v_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        stb_d   = 1'b0;
        wait_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      dl_active_q <= 1'b0;
      stb_q       <= 1'b0;
      wait_q      <= 1'b0;
      sel_q       <= 4'd0;
      adr_q       <= '0;
      dat_q       <= 32'd0;
      erase_cnt_q <= '0;
      hold_v_q    <= 1'b0;
      hold_q      <= 16'd0;
      hold_adr_q  <= '0;
      pend_v_q    <= 1'b0;
      pend_dat_q  <= 16'd0;
      pend_adr_q  <= '0;
    end else begin
      state_q     <= state_d;
      dl_active_q <= dl_active_i;
      stb_q       <= stb_d;
      wait_q      <= wait_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      erase_cnt_q <= erase_cnt_d;
      hold_v_q    <= hold_v_d;
      hold_q      <= hold_d;
      hold_adr_q  <= hold_adr_d;
      pend_v_q    <= pend_v_d;
      pend_dat_q  <= pend_dat_d;
      pend_adr_q  <= pend_adr_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      checksum_q <= 32'd0;
    end else if (state_q == IDLE && state_d == ERASE) begin
      checksum_q <= 32'd0;
    end else if (accept_wr) begin
      checksum_q <= checksum_q + {16'd0, dl_data_i};
    end
  end

  assign checksum_o = checksum_q;
`else
  logic unused_accept_wr;

  assign unused_accept_wr = accept_wr;
  assign checksum_o       = 32'd0;
`endif

  assign dl_wait_o = wait_q;
  assign wb_cyc_o  = stb_q;
  assign wb_stb_o  = stb_q;
  assign own_bus_o = (state_q != IDLE);
  assign wb_we_o   = own_bus_o;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_wb_rom_loader.sv
// Directed bench for wb_rom_loader: one packing and one non-packing instance share the ioctl stimulus.
module tb_wb_rom_loader;

  typedef struct packed {
    logic [21:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } bw_t;

  typedef struct {
    logic [24:0] addr;
    logic [15:0] data;
    int          np;
    bw_t         p0;
    bw_t         p1;
    bw_t         n0;
  } vec_t;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset, dl_active, dl_wr;
  logic [24:0] dl_addr;
  logic [15:0] dl_data;

  logic        wait_p, cyc_p, stb_p, we_p, ack_p, own_p, done_op;
  logic [3:0]  sel_p;
  logic [21:0] adr_p;
  logic [31:0] dat_p, csum_p;
  logic        wait_n, cyc_n, stb_n, we_n, ack_n, own_n, done_on;
  logic [3:0]  sel_n;
  logic [21:0] adr_n;
  logic [31:0] dat_n, csum_n;

  wb_rom_loader #(.ADDR_W(22), .BASE_WORD(22'h100000), .REGION_LOG2(4), .PACK(1'b1)) u_pack (
    .clk_sys(clk_sys), .reset(reset), .dl_active_i(dl_active), .dl_wr_i(dl_wr),
    .dl_addr_i(dl_addr), .dl_data_i(dl_data), .dl_wait_o(wait_p), .wb_cyc_o(cyc_p),
    .wb_stb_o(stb_p), .wb_we_o(we_p), .wb_sel_o(sel_p), .wb_adr_o(adr_p), .wb_dat_o(dat_p),
    .wb_ack_i(ack_p), .own_bus_o(own_p), .done_o(done_op), .checksum_o(csum_p));

  wb_rom_loader #(.ADDR_W(22), .BASE_WORD(22'h100000), .REGION_LOG2(4), .PACK(1'b0)) u_nopack (
    .clk_sys(clk_sys), .reset(reset), .dl_active_i(dl_active), .dl_wr_i(dl_wr),
    .dl_addr_i(dl_addr), .dl_data_i(dl_data), .dl_wait_o(wait_n), .wb_cyc_o(cyc_n),
    .wb_stb_o(stb_n), .wb_we_o(we_n), .wb_sel_o(sel_n), .wb_adr_o(adr_n), .wb_dat_o(dat_n),
    .wb_ack_i(ack_n), .own_bus_o(own_n), .done_o(done_on), .checksum_o(csum_n));

  bw_t q_p[$];
  bw_t q_n[$];
  int  ack_dly = 0;
  int  cnt_p = 0, cnt_n = 0;
  int  done_p = 0, done_n = 0;
  int  n_checks = 0, n_fail = 0;
  vec_t vt[6];

`ifdef LOADER_CHECKSUM_EN
  localparam logic [31:0] EXP_SUM1 = 32'h000179BC;
  localparam logic [31:0] EXP_SUM2 = 32'h00010002;
`else
  localparam logic [31:0] EXP_SUM1 = 32'd0;
  localparam logic [31:0] EXP_SUM2 = 32'd0;
`endif

  // Slave models: ack after ack_dly idle negedges, log each acknowledged write.
  always @(negedge clk_sys) begin
    if (reset) begin
      ack_p = 1'b0; cnt_p = 0;
    end else if (ack_p) begin
      ack_p = 1'b0;
    end else if (stb_p) begin
      if (cnt_p >= ack_dly) begin
        ack_p = 1'b1; cnt_p = 0; q_p.push_back({adr_p, dat_p, sel_p});
      end else cnt_p++;
    end
    if (done_op) done_p++;
  end

  always @(negedge clk_sys) begin
    if (reset) begin
      ack_n = 1'b0; cnt_n = 0;
    end else if (ack_n) begin
      ack_n = 1'b0;
    end else if (stb_n) begin
      if (cnt_n >= ack_dly) begin
        ack_n = 1'b1; cnt_n = 0; q_n.push_back({adr_n, dat_n, sel_n});
      end else cnt_n++;
    end
    if (done_on) done_n++;
  end

  function automatic bw_t mk(input logic [21:0] a, input logic [31:0] d, input logic [3:0] s);
    return {a, d, s};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_wr(input logic [24:0] a, input logic [15:0] d, input logic active);
    @(posedge clk_sys); #1;
    dl_wr = 1'b1; dl_addr = a; dl_data = d; dl_active = active;
    @(posedge clk_sys); #1;
    dl_wr = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk_sys);
      if (!wait_p && !wait_n && !stb_p && !stb_n) break;
    end
    chk({name, "_timeout"}, 64'(i < max), 64'd1);
  endtask

  task automatic wait_done(input string name, input int exp_done);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (done_p >= exp_done && done_n >= exp_done && !own_p && !own_n) break;
    end
    chk({name, "_timeout"}, 64'(i < 100), 64'd1);
  endtask

  task automatic start_dl();
    @(posedge clk_sys); #1;
    dl_active = 1'b1;
    @(posedge clk_sys);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{25'h00, 16'h1234, 0, mk(22'h0, 32'h0, 4'h0), mk(22'h0, 32'h0, 4'h0),
              mk(22'h100000, 32'h12341234, 4'h3)};
    vt[1] = '{25'h02, 16'hABCD, 1, mk(22'h100000, 32'hABCD1234, 4'hF), mk(22'h0, 32'h0, 4'h0),
              mk(22'h100000, 32'hABCDABCD, 4'hC)};
    vt[2] = '{25'h04, 16'h1111, 0, mk(22'h0, 32'h0, 4'h0), mk(22'h0, 32'h0, 4'h0),
              mk(22'h100001, 32'h11111111, 4'h3)};
    vt[3] = '{25'h0A, 16'h2222, 2, mk(22'h100001, 32'h11111111, 4'h3),
              mk(22'h100002, 32'h22222222, 4'hC), mk(22'h100002, 32'h22222222, 4'hC)};
    vt[4] = '{25'h46, 16'h3333, 1, mk(22'h100001, 32'h33333333, 4'hC), mk(22'h0, 32'h0, 4'h0),
              mk(22'h100001, 32'h33333333, 4'hC)};
    vt[5] = '{25'h3D, 16'h5555, 0, mk(22'h0, 32'h0, 4'h0), mk(22'h0, 32'h0, 4'h0),
              mk(22'h10000F, 32'h55555555, 4'h3)};

    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_stb", {63'd0, stb_p}, 64'd0);
    chk("rst_own_bus", {63'd0, own_p}, 64'd0);
    chk("rst_dl_wait", {63'd0, wait_p}, 64'd0);
    chk("rst_done", {63'd0, done_op}, 64'd0);
    chk("rst_sel_adr_dat", {sel_p, adr_p, dat_p}, 64'd0);
    chk("rst_checksum", {32'd0, csum_p}, 64'd0);

    // Erase of a 16-word region
    start_dl();
    @(negedge clk_sys);
    chk("erase_start_wait", {62'd0, wait_p, stb_p}, 64'd3);
    chk("erase_start_own_we", {62'd0, own_p, we_p}, 64'd3);
    chk("erase_start_adr", {42'd0, adr_p}, 64'h100000);
    wait_quiet("erase", 200);
    chk("erase_count_pack", 64'(q_p.size()), 64'd16);
    chk("erase_count_nopack", 64'(q_n.size()), 64'd16);
    for (int i = 0; i < 16 && i < q_p.size(); i++)
      chk("erase_write", 64'(q_p[i]), 64'(mk(22'h100000 + 22'(i), 32'd0, 4'hF)));
    chk("load_own_bus", {63'd0, own_p}, 64'd1);
    q_p.delete(); q_n.delete();

    for (int v = 0; v < 6; v++) begin
      do_wr(vt[v].addr, vt[v].data, 1'b1);
      wait_quiet("vec", 50);
      chk("vec_cnt_pack", 64'(q_p.size()), 64'(vt[v].np));
      if (vt[v].np > 0 && q_p.size() > 0) chk("vec_pack_w0", 64'(q_p[0]), 64'(vt[v].p0));
      if (vt[v].np > 1 && q_p.size() > 1) chk("vec_pack_w1", 64'(q_p[1]), 64'(vt[v].p1));
      chk("vec_cnt_nopack", 64'(q_n.size()), 64'd1);
      if (q_n.size() > 0) chk("vec_nopack_w0", 64'(q_n[0]), 64'(vt[v].n0));
      q_p.delete(); q_n.delete();
    end

    // End of download with a low half still held
    @(posedge clk_sys); #1 dl_active = 1'b0;
    wait_done("end1", 1);
    chk("flush_cnt_pack", 64'(q_p.size()), 64'd1);
    if (q_p.size() > 0) chk("flush_write", 64'(q_p[0]), 64'(mk(22'h10000F, 32'h55555555, 4'h3)));
    chk("flush_cnt_nopack", 64'(q_n.size()), 64'd0);
    repeat (4) @(negedge clk_sys);
    chk("done_once_pack", 64'(done_p), 64'd1);
    chk("done_once_nopack", 64'(done_n), 64'd1);
    chk("sum1_pack", {32'd0, csum_p}, {32'd0, EXP_SUM1});
    chk("sum1_nopack", {32'd0, csum_n}, {32'd0, EXP_SUM1});

    // Second download, last write coincides with dl_active falling
    q_p.delete(); q_n.delete();
    start_dl();
    wait_quiet("erase2", 200);
    chk("sum_cleared", {32'd0, csum_p}, 64'd0);
    q_p.delete(); q_n.delete();
    do_wr(25'h0, 16'hFFFF, 1'b1);
    wait_quiet("s2a", 50);
    do_wr(25'h2, 16'h0001, 1'b1);
    wait_quiet("s2b", 50);
    do_wr(25'h4, 16'h0002, 1'b0);
    wait_done("end2", 2);
    chk("s2_cnt_pack", 64'(q_p.size()), 64'd2);
    if (q_p.size() > 1) begin
      chk("s2_pack_w0", 64'(q_p[0]), 64'(mk(22'h100000, 32'h0001FFFF, 4'hF)));
      chk("s2_pack_w1", 64'(q_p[1]), 64'(mk(22'h100001, 32'h00020002, 4'h3)));
    end
    chk("s2_cnt_nopack", 64'(q_n.size()), 64'd3);
    if (q_n.size() > 2) begin
      chk("s2_nopack_w0", 64'(q_n[0]), 64'(mk(22'h100000, 32'hFFFFFFFF, 4'h3)));
      chk("s2_nopack_w1", 64'(q_n[1]), 64'(mk(22'h100000, 32'h00010001, 4'hC)));
      chk("s2_nopack_w2", 64'(q_n[2]), 64'(mk(22'h100001, 32'h00020002, 4'h3)));
    end
    chk("sum2_pack", {32'd0, csum_p}, {32'd0, EXP_SUM2});
    chk("done_twice", 64'(done_p), 64'd2);

    // Slow slave: stb and dl_wait must hold, then reset aborts mid-erase
    q_p.delete(); q_n.delete();
    ack_dly = 5;
    start_dl();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      chk("slow_hold", {41'd0, wait_p, stb_p, adr_p}, {41'd0, 2'b11, 22'h100000});
    end
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        @(negedge clk_sys);
        if (q_p.size() >= 2) break;
      end
      chk("slow_progress_timeout", 64'(k < 100), 64'd1);
    end
    chk("slow_still_erasing", {62'd0, own_p, stb_p}, 64'd3);
    @(posedge clk_sys); #1;
    reset = 1'b1; dl_active = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("abort_stb", {63'd0, stb_p}, 64'd0);
    chk("abort_own_bus", {63'd0, own_p}, 64'd0);
    chk("abort_dl_wait", {63'd0, wait_p}, 64'd0);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
